// File: rtl/uart_module_nios2_gen2_cpu_debug_host_scan_if.sv
// Command/response handshake bundle between a scan requester
// and the virtual-JTAG host scan engine.
interface uart_module_nios2_gen2_cpu_debug_host_scan_if #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_dr;
    logic [IR_WIDTH-1:0] rsp_ir_out;

    modport master (
        output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
    );
endinterface

// File: rtl/uart_module_nios2_gen2_cpu_debug_host_scan.sv
// Host-side virtual-JTAG scan engine: loads IR, runs one full DR
// scan per command and returns the captured tdo word.
module uart_module_nios2_gen2_cpu_debug_host_scan #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    uart_module_nios2_gen2_cpu_debug_host_scan_if.slave bus,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);
    localparam int PER = 2 * TCK_DIV;
    localparam int PW  = (PER > 1) ? $clog2(PER) : 1;
    localparam int BW  = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam logic [PW-1:0] PH_RISE  = PW'(TCK_DIV - 1);
    localparam logic [PW-1:0] PH_END   = PW'(PER - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_UIR, S_CDR, S_SHIFT, S_UDR, S_RTI, S_RESP
    } st_t;

    st_t                 st;
    logic [PW-1:0]       ph;
    logic [BW-1:0]       bit_cnt;
    logic [DR_WIDTH-1:0] sr;
    logic [4:0]          strb;

    // Strobe bundle order: {uir, cdr, sdr, udr, rti}
    function automatic logic [4:0] strb_of(st_t s);
        case (s)
            S_UIR:   return 5'b10000;
            S_CDR:   return 5'b01000;
            S_SHIFT: return 5'b00100;
            S_UDR:   return 5'b00010;
            S_RTI:   return 5'b00001;
            S_IDLE:  return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    logic rise, last;
    assign rise = (ph == PH_RISE);
    assign last = (ph == PH_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            st             <= S_IDLE;
            ph             <= '0;
            bit_cnt        <= '0;
            sr             <= '0;
            strb           <= 5'b00001;
            vji_tck        <= 1'b0;
            vji_tdi        <= 1'b0;
            vji_ir_in      <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_dr     <= '0;
            bus.rsp_ir_out <= '0;
        end else begin
            unique case (st)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        st        <= S_UIR;
                        strb      <= strb_of(S_UIR);
                        vji_ir_in <= bus.cmd_ir;
                        sr        <= bus.cmd_dr;
                        ph        <= '0;
                        vji_tck   <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        st            <= S_IDLE;
                        strb          <= strb_of(S_IDLE);
                        bus.rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    // tck rises on the edge after phase TCK_DIV-1
                    if (last) begin
                        ph      <= '0;
                        vji_tck <= 1'b0;
                    end else begin
                        ph      <= ph + 1'b1;
                        vji_tck <= (ph >= PH_RISE);
                    end
                    if (rise && st == S_UIR)
                        bus.rsp_ir_out <= vji_ir_out;
                    if (rise && st == S_SHIFT)
                        sr <= {vji_tdo, sr[DR_WIDTH-1:1]};
                    if (last) begin
                        case (st)
                            S_UIR: begin
                                st   <= S_CDR;
                                strb <= strb_of(S_CDR);
                            end
                            S_CDR: begin
                                st      <= S_SHIFT;
                                strb    <= strb_of(S_SHIFT);
                                bit_cnt <= '0;
                                vji_tdi <= sr[0];
                            end
                            S_SHIFT: begin
                                if (bit_cnt == BIT_LAST) begin
                                    st      <= S_UDR;
                                    strb    <= strb_of(S_UDR);
                                    vji_tdi <= 1'b0;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                    vji_tdi <= sr[0];
                                end
                            end
                            S_UDR: begin
                                st   <= S_RTI;
                                strb <= strb_of(S_RTI);
                            end
                            default: begin
                                st            <= S_RESP;
                                strb          <= strb_of(S_RESP);
                                bus.rsp_valid <= 1'b1;
                                bus.rsp_dr    <= sr;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} = strb;
    assign bus.cmd_ready = (st == S_IDLE) && !reset;
endmodule

// File: doc/uart_module_nios2_gen2_cpu_debug_host_scan.md
# uart_module_nios2_gen2_cpu_debug_host_scan

Host-side scan engine that drives the virtual-JTAG signal set of the Nios II debug slave (tck, tdi, ir_in, uir/cdr/sdr/udr/rti strobes) and captures its tdo and ir_out. Each command loads a 2-bit instruction, then performs one full 38-bit DR scan and returns the captured word. The block replaces the sld_virtual_jtag_basic hub in simulation and on-chip self-test builds. It sits between a command source (test sequencer or bus bridge) and the debug slave wrapper's vji_* nets.

## Interface
- DR_WIDTH, 38, scan-chain length in bits.
- IR_WIDTH, 2, instruction register width.
- TCK_DIV, 2, clk cycles per tck half-period (≥1); one tck period = 2*TCK_DIV clk cycles.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_ir  in  IR_WIDTH  instruction to load.
- cmd_dr  in  DR_WIDTH  data to shift in, LSB first.
- rsp_valid  out  1  response word available.
- rsp_ready  in  1  consumer takes response.
- rsp_dr  out  DR_WIDTH  captured tdo bits.
- rsp_ir_out  out  IR_WIDTH  vji_ir_out sampled during UIR.
- vji_tck  out  1  generated test clock.
- vji_tdi  out  1  serial data to slave.
- vji_tdo  in  1  serial data from slave.
- vji_ir_in  out  IR_WIDTH  instruction presented to slave.
- vji_ir_out  in  IR_WIDTH  slave status bits.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual-state strobes.

## Operation
- States: IDLE, UIR, CDR, SHIFT, UDR, RTI, RESP. Every state except IDLE/RESP lasts whole tck periods.
- IDLE: cmd_ready=1, vji_rti=1, tck=0. On cmd_valid&&cmd_ready: latch cmd_ir to vji_ir_in, cmd_dr to shift register sr, go to UIR.
- UIR (1 period): vji_uir=1; vji_ir_out sampled into rsp_ir_out at the tck rising edge.
- CDR (1 period): vji_cdr=1.
- SHIFT (DR_WIDTH periods): vji_sdr=1; vji_tdi=sr[0], stable for whole period; at each tck rise sr <= {vji_tdo, sr[DR_WIDTH-1:1]}. Bit counter counts 0..DR_WIDTH-1; leaves on last rise's period end.
- UDR (1 period): vji_udr=1. RTI (1 period): vji_rti=1. Then RESP.
- RESP: rsp_valid=1, rsp_dr=sr held stable; on rsp_ready go IDLE. cmd_ready=0 in every state but IDLE.
- Exactly one strobe (uir/cdr/sdr/udr/rti) high in UIR..RTI; rti also high in IDLE; all strobes 0 in RESP.
- vji_ir_in holds latched value until next accept; vji_tdi=0 outside SHIFT.
- Reset (any state, incl. mid-SHIFT): next edge state=IDLE, tck=0, all strobes 0 except rti=1, vji_ir_in=0, vji_tdi=0, sr=0, rsp_dr=0, rsp_ir_out=0, rsp_valid=0; cmd_ready=0 while reset high, 1 first cycle after. Partial scan discarded, no response.
- cmd_valid during non-IDLE ignored (not latched).

## Timing
- tck: low for first TCK_DIV clk cycles of each period, high for next TCK_DIV. Strobe/tdi changes coincide with tck falling (period start); samples taken on the clk edge where tck goes high.
- Accept at edge 0 -> UIR starts cycle 1 -> rsp_valid at cycle 1+(DR_WIDTH+4)*2*TCK_DIV (defaults: cycle 169).
- rsp_ready sampled same cycle rsp_valid=1 -> IDLE next cycle; back-to-back commands: 1 idle cycle minimum between rsp handshake and next accept.
- All outputs registered or decoded from registered state; no combinational path from inputs to outputs except none (cmd_ready depends only on state and reset).

## Test plan
- Basic scan: cmd_ir=2'b10, cmd_dr=38'h2A_5A5A_5A5A, tdo looped from a 38-bit model shift reg preloaded 38'h15_A5A5_A5A5 -> rsp_dr=38'h15_A5A5_A5A5, model holds 38'h2A_5A5A_5A5A at udr, rsp_valid at cycle 169.
- Strobe order: check uir, cdr, 38 sdr periods, udr, rti each exactly 4 clk long, one-hot, tdi LSB-first; vji_ir_out=2'b01 -> rsp_ir_out=2'b01.
- Back-pressure: hold rsp_ready=0 for 50 cycles -> rsp_valid/rsp_dr stable, cmd_ready=0, second cmd_valid not accepted.
- Reset at SHIFT bit 17 -> next cycle all outputs at reset values, no rsp_valid; following command completes normally.
- TCK_DIV=1, DR_WIDTH=38 -> tck period 2 clk, rsp_valid at cycle 85; tdo constant 1 -> rsp_dr=38'h3F_FFFF_FFFF.
- Back-to-back: three commands with rsp_ready tied 1 -> each accepted one cycle after prior response, responses in order, correct data.
